// File: rtl/studio_keypad.sv
`timescale 1ns/1ps
// Keypad controller: PS/2 events -> per-pad held bitmaps, CPU-selected key -> active-low EF per pad.
// Latency: key_held updates on the event edge, ef_n/any_key one edge later; no back-pressure.
// STUDIO_KEYPAD_STRETCH_EN keeps short taps visible for MIN_HOLD cycles after the last press on a pad.
module studio_keypad #(
    parameter int NUM_PADS = 2,
    parameter int MIN_HOLD = 20000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [10:0]              ps2_key,
    input  logic                     sel_wr,
    input  logic [7:0]               sel_din,
    output logic [NUM_PADS-1:0]      ef_n,
    output logic [NUM_PADS*10-1:0]   key_held,
    output logic [NUM_PADS-1:0]      any_key
);
    localparam int HW = NUM_PADS * 10;

    // Encoding: {valid, pad[1:0], key[3:0]}
    function automatic logic [6:0] map_code(input logic [7:0] code);
        logic [6:0] r;
        r = '0;
        case (code)
            8'h16: r = 7'h41;  8'h1E: r = 7'h42;  8'h26: r = 7'h43;  8'h25: r = 7'h44;  8'h2E: r = 7'h45;
            8'h36: r = 7'h46;  8'h3D: r = 7'h47;  8'h3E: r = 7'h48;  8'h46: r = 7'h49;  8'h45: r = 7'h40;
            8'h69: r = 7'h51;  8'h72: r = 7'h52;  8'h7A: r = 7'h53;  8'h6B: r = 7'h54;  8'h73: r = 7'h55;
            8'h74: r = 7'h56;  8'h6C: r = 7'h57;  8'h75: r = 7'h58;  8'h7D: r = 7'h59;  8'h70: r = 7'h50;
            8'h15: r = 7'h61;  8'h1D: r = 7'h62;  8'h24: r = 7'h63;  8'h2D: r = 7'h64;  8'h2C: r = 7'h65;
            8'h35: r = 7'h66;  8'h3C: r = 7'h67;  8'h43: r = 7'h68;  8'h44: r = 7'h69;  8'h4D: r = 7'h60;
            8'h1C: r = 7'h71;  8'h1B: r = 7'h72;  8'h23: r = 7'h73;  8'h2B: r = 7'h74;  8'h34: r = 7'h75;
            8'h33: r = 7'h76;  8'h3B: r = 7'h77;  8'h42: r = 7'h78;  8'h4B: r = 7'h79;  8'h4C: r = 7'h70;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic                tog_q;
    logic [3:0]          sel;
    logic [6:0]          m;
    logic                hit;
    logic                pressed;
    logic [5:0]          bit_idx;
    logic [HW-1:0]       hit_mask;
    logic [HW-1:0]       held_nxt;
    logic [NUM_PADS-1:0] ef_nxt;
    logic [NUM_PADS-1:0] any_nxt;
    logic [9:0]          pad_bits;
    logic                unused_sel_hi;

    assign unused_sel_hi = ^sel_din[7:4];
    assign m             = map_code(ps2_key[7:0]);
    assign pressed       = ps2_key[9];
    assign hit           = (ps2_key[10] != tog_q) && !ps2_key[8] && m[6] && (32'(m[5:4]) < NUM_PADS);
    assign bit_idx       = {4'b0, m[5:4]} * 6'd10 + {2'b0, m[3:0]};
    assign hit_mask      = HW'(1'b1) << bit_idx;

`ifdef STUDIO_KEYPAD_STRETCH_EN
    logic [15:0]   cnt_q   [NUM_PADS];
    logic [15:0]   cnt_nxt [NUM_PADS];
    logic [HW-1:0] pend_q;
    logic [HW-1:0] pend_nxt;
    logic [15:0]   cnt_sel;

    always_comb begin
        held_nxt = key_held;
        pend_nxt = pend_q;
        cnt_sel  = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (hit && pressed && m[5:4] == 2'(p))
                cnt_nxt[p] = 16'(MIN_HOLD);
            else if (cnt_q[p] != 16'd0)
                cnt_nxt[p] = cnt_q[p] - 16'd1;
            else
                cnt_nxt[p] = cnt_q[p];
            // Counter reaching zero releases every deferred key of the pad at once
            if (cnt_q[p] == 16'd1 && !(hit && pressed && m[5:4] == 2'(p))) begin
                held_nxt = held_nxt & ~(pend_q & (HW'(10'h3FF) << (10 * p)));
                pend_nxt = pend_nxt & ~(HW'(10'h3FF) << (10 * p));
            end
            if (m[5:4] == 2'(p))
                cnt_sel = cnt_q[p];
        end
        if (hit) begin
            if (pressed) begin
                held_nxt = held_nxt | hit_mask;
                pend_nxt = pend_nxt & ~hit_mask;
            end else if (cnt_sel > 16'd1 && (key_held & hit_mask) != '0) begin
                pend_nxt = pend_nxt | hit_mask;
            end else begin
                held_nxt = held_nxt & ~hit_mask;
                pend_nxt = pend_nxt & ~hit_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PADS; p++) cnt_q[p] <= '0;
            pend_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PADS; p++) cnt_q[p] <= cnt_nxt[p];
            pend_q <= pend_nxt;
        end
    end
`else
    always_comb begin
        held_nxt = key_held;
        if (hit)
            held_nxt = pressed ? (key_held | hit_mask) : (key_held & ~hit_mask);
    end
`endif

    always_comb begin
        ef_nxt   = '1;
        any_nxt  = '0;
        pad_bits = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            pad_bits   = key_held[p*10 +: 10];
            any_nxt[p] = |pad_bits;
            ef_nxt[p]  = !((sel <= 4'd9) && pad_bits[sel]);
        end
    end

    // tog_q tracks the toggle through reset so releasing reset never fabricates an event
    always_ff @(posedge clk) begin
        tog_q <= ps2_key[10];
        if (reset) begin
            key_held <= '0;
            sel      <= '0;
            ef_n     <= '1;
            any_key  <= '0;
        end else begin
            key_held <= held_nxt;
            if (sel_wr)
                sel <= sel_din[3:0];
            ef_n    <= ef_nxt;
            any_key <= any_nxt;
        end
    end
endmodule

// File: tb/tb_studio_keypad.sv
`timescale 1ns/1ps
// Scoreboard bench for studio_keypad: a behavioural model pushes expected outputs per edge, a monitor pops and compares.
module tb_studio_keypad;
    localparam int NP = 2;
    localparam int MH = 8;
`ifdef STUDIO_KEYPAD_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   ps2_key;
    logic          sel_wr;
    logic [7:0]    sel_din;
    logic [NP-1:0] ef_n;
    logic [NP*10-1:0] key_held;
    logic [NP-1:0] any_key;

    always #5 clk = ~clk;

    studio_keypad #(.NUM_PADS(NP), .MIN_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .sel_wr(sel_wr), .sel_din(sel_din),
        .ef_n(ef_n), .key_held(key_held), .any_key(any_key)
    );

    typedef struct packed {
        logic [19:0] held;
        logic [1:0]  ef;
        logic [1:0]  any;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic tog         = 1'b0;
    int   cyc_n       = 0;
    bit   m_held [NP][10];
    bit   m_pend [NP][10];
    int   last_press [NP];
    logic [3:0] m_sel;

    byte unsigned kmap [4][10] = '{
        '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45},
        '{8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D, 8'h70},
        '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D},
        '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C}
    };

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Table position i holds key (i+1)%10: keys 1..9 then 0
    task automatic lookup(input logic [7:0] code, output int pad, output int key);
        pad = -1;
        key = 0;
        for (int pp = 0; pp < 4; pp++)
            for (int i = 0; i < 10; i++)
                if (kmap[pp][i] == code) begin
                    pad = pp;
                    key = (i + 1) % 10;
                end
    endtask

    task automatic model_edge(input logic rst, input logic ev, input logic pr, input logic ex,
                              input logic [7:0] code, input logic wr, input logic [7:0] din);
        exp_t e;
        int pad, key;
        logic [1:0] ef_new, any_new;
        cyc_n++;
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                last_press[p] = -100000;
                for (int k = 0; k < 10; k++) begin
                    m_held[p][k] = 1'b0;
                    m_pend[p][k] = 1'b0;
                end
            end
            m_sel   = 4'd0;
            ef_new  = 2'b11;
            any_new = 2'b00;
        end else begin
            for (int p = 0; p < NP; p++) begin
                any_new[p] = 1'b0;
                for (int k = 0; k < 10; k++) any_new[p] = any_new[p] | m_held[p][k];
                ef_new[p] = !(m_sel <= 4'd9 && m_held[p][m_sel]);
            end
            lookup(code, pad, key);
            if (!(ev && !ex && pad >= 0 && pad < NP)) pad = -1;
            if (STRETCH)
                for (int p = 0; p < NP; p++)
                    if (!(pad == p && pr) && cyc_n == last_press[p] + MH)
                        for (int k = 0; k < 10; k++)
                            if (m_pend[p][k]) begin
                                m_held[p][k] = 1'b0;
                                m_pend[p][k] = 1'b0;
                            end
            if (pad >= 0) begin
                if (pr) begin
                    m_held[pad][key] = 1'b1;
                    m_pend[pad][key] = 1'b0;
                    last_press[pad]  = cyc_n;
                end else if (STRETCH && m_held[pad][key] && cyc_n < last_press[pad] + MH) begin
                    m_pend[pad][key] = 1'b1;
                end else begin
                    m_held[pad][key] = 1'b0;
                    m_pend[pad][key] = 1'b0;
                end
            end
            if (wr) m_sel = din[3:0];
        end
        e.held = '0;
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 10; k++)
                e.held[p*10+k] = m_held[p][k];
        e.ef  = ef_new;
        e.any = any_new;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic ev, input logic pr, input logic ex, input logic [7:0] code,
                       input logic wr, input logic [7:0] din);
        if (ev) tog = ~tog;
        ps2_key = {tog, pr, ex, code};
        sel_wr  = wr;
        sel_din = din;
        @(posedge clk);
        model_edge(reset, ev, pr, ex, code, wr, din);
        #1;
        sel_wr = 1'b0;
    endtask

    task automatic press(input logic [7:0] code);   cyc(1'b1, 1'b1, 1'b0, code, 1'b0, 8'h00); endtask
    task automatic release_key(input logic [7:0] code); cyc(1'b1, 1'b0, 1'b0, code, 1'b0, 8'h00); endtask
    task automatic idle();                          cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00); endtask
    task automatic wsel(input logic [7:0] d);       cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, d); endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_key_held", 32'(key_held), 32'(e.held));
            chk("sb_ef_n",     32'(ef_n),     32'(e.ef));
            chk("sb_any_key",  32'(any_key),  32'(e.any));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        ps2_key = '0;
        sel_wr  = 1'b0;
        sel_din = '0;
        idle();
        idle();
        reset = 1'b0;
        chk("rst_ef_n",     32'(ef_n),     32'h3);
        chk("rst_key_held", 32'(key_held), 32'h0);
        chk("rst_any_key",  32'(any_key),  32'h0);

        // Digit '5' on pad 0, then select key 5
        press(8'h2E);
        wsel(8'h05);
        chk("sel_latency_ef", 32'(ef_n), 32'h3);
        idle();
        chk("p0_k5_held", 32'(key_held[5]), 32'h1);
        chk("p0_any",     32'(any_key[0]),  32'h1);
        chk("p0_k5_ef",   32'(ef_n),        32'h2);

        // Keypad-5 on pad 1 only, then move the selection away
        release_key(8'h2E);
        press(8'h73);
        idle();
        chk("p1_k5_ef", 32'(ef_n), 32'h1);
        wsel(8'h06);
        chk("sel6_latency_ef", 32'(ef_n), 32'h1);
        idle();
        chk("sel6_ef", 32'(ef_n), 32'h3);

        // Release, duplicate release, extended code
        press(8'h16);
        press(8'h1E);
        release_key(8'h16);
        chk("rel_16", 32'(key_held[2:1]), 32'h2);
        release_key(8'h16);
        chk("rel_16_again", 32'(key_held[2:1]), 32'h2);
        cyc(1'b1, 1'b1, 1'b1, 8'h16, 1'b0, 8'h00);
        chk("ext_16_ignored", 32'(key_held[2:1]), 32'h2);

        // Out-of-range select, then same-cycle select write and press
        press(8'h45);
        wsel(8'hFA);
        idle();
        chk("sel10_ef", 32'(ef_n), 32'h3);
        cyc(1'b1, 1'b1, 1'b0, 8'h26, 1'b1, 8'h03);
        idle();
        chk("same_cycle_ef", 32'(ef_n), 32'h2);

        // Back-to-back events, pad beyond NUM_PADS, unmapped code
        press(8'h69);
        press(8'h72);
        press(8'h7A);
        release_key(8'h72);
        press(8'h15);
        press(8'h5A);
        chk("pad1_bitmap", 32'(key_held[19:10]), 32'h02A);
        idle();
        chk("any_both", 32'(any_key), 32'h3);

        // Reset mid-hold with a toggle flip during reset
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 8'h46, 1'b0, 8'h00);
        reset = 1'b0;
        chk("midrst_held", 32'(key_held), 32'h0);
        chk("midrst_ef",   32'(ef_n),     32'h3);
        chk("midrst_any",  32'(any_key),  32'h0);
        idle();
        chk("no_phantom", 32'(key_held), 32'h0);

`ifdef STUDIO_KEYPAD_STRETCH_EN
        // Short tap on '1' stays visible until MH edges after the press
        press(8'h16);
        idle();
        release_key(8'h16);
        for (int i = 3; i <= MH; i++) begin
            idle();
            chk("stretch_tap", 32'(key_held[1]), (i < MH) ? 32'h1 : 32'h0);
        end
        // Re-press while pending cancels the deferred release
        press(8'h16);
        idle();
        release_key(8'h16);
        idle();
        press(8'h16);
        for (int i = 5; i <= MH + 5; i++) begin
            idle();
            chk("stretch_repress", 32'(key_held[1]), 32'h1);
        end
        release_key(8'h16);
        for (int i = 0; i < MH; i++) idle();
        chk("stretch_final", 32'(key_held[1]), 32'h0);
`endif

        // Random traffic checked through the scoreboard
        for (int n = 0; n < 400; n++) begin
            logic [7:0] code;
            if ($urandom_range(7) == 0) code = 8'h5A;
            else code = kmap[$urandom_range(3)][$urandom_range(9)];
            cyc(($urandom_range(9) < 7) ? 1'b1 : 1'b0, 1'($urandom_range(1)),
                ($urandom_range(9) == 0) ? 1'b1 : 1'b0, code,
                ($urandom_range(4) == 0) ? 1'b1 : 1'b0, 8'($urandom_range(255)));
        end
        idle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
